counter_snapshot_serializer: RTL and testbench
==============================================

Name: counter_snapshot_serializer

Overview:
- Downstream consumer of the dual 64-bit counter block's Output0/Output1 buses.
- On a snapshot request, atomically captures both counter values in one cycle.
- Streams the capture out as a framed byte sequence over a valid/ready interface: 1 header byte, then Cnt0 bytes, then Cnt1 bytes.
- Feeds the debug/UART-style byte sink, so counter values can be observed off-chip without stalling the counters.

Parameters:
- DW, 64, width of each counter input; must be a multiple of 8.
- LSB_FIRST, 1, 1 = least-significant byte of each counter sent first; 0 = most-significant first.
- HDR, 8'hA5, header byte sent at the start of every frame.

Ports:
- Clk  input  1  system clock; all state updates on rising edge.
- Reset  input  1  synchronous, active-high reset.
- Snap  input  1  snapshot request, sampled each rising edge.
- Cnt0  input  DW  counter 0 value (from Output0).
- Cnt1  input  DW  counter 1 value (from Output1).
- Ready  input  1  sink can accept a byte this cycle.
- Valid  output  1  DataOut holds a valid byte.
- DataOut  output  8  current frame byte.
- Last  output  1  high with Valid on the final byte of a frame.
- Busy  output  1  a frame is in progress.
- Overrun  output  8  saturating count of rejected Snap requests.

Behaviour:
- Clock and reset: one clock (Clk); reset is synchronous and active-high (Reset).
- Reset values: Valid=0, DataOut=0, Last=0, Busy=0, Overrun=0, snapshot registers=0, state=IDLE, byte index=0.
- Reset is checked before all other logic and aborts any frame immediately. No partial frame resumes after reset.
- Frame length is N = 1 + 2*DW/8 beats (17 for DW=64).
- Beat order:
  - Beat 0: HDR.
  - Beats 1..DW/8: bytes of captured Cnt0.
  - Remaining beats: bytes of captured Cnt1.
  - Byte order within each counter is set by LSB_FIRST.
- States:
  - IDLE: Valid=0, Busy=0. If Snap=1 at an edge, latch Cnt0/Cnt1 and go to HDR.
  - HDR: Valid=1, DataOut=HDR, Busy=1. On Valid&&Ready, go to DATA with index=0.
  - DATA: Valid=1, DataOut=selected byte of the snapshot, Busy=1.
    - On Valid&&Ready, index increments.
    - On the handshake with index=2*DW/8-1 (Last=1), return to IDLE, or restart at HDR if a snapshot is accepted on the same edge.
- Latency: Snap accepted at edge k gives Valid=1 with the header during cycle k+1 (one-cycle latency).
- Handshake:
  - A transfer occurs only on a rising edge with Valid=1 and Ready=1.
  - While Valid=1 and Ready=0, DataOut and Last hold stable.
  - Valid never drops without a transfer, except on Reset.
- Snapshot atomicity: Cnt0 and Cnt1 are latched on the same edge. Later input changes do not affect the frame in progress.
- Snap acceptance:
  - Accepted when state=IDLE.
  - Also accepted on the edge that completes the Last handshake. This gives back-to-back frames: the header appears in the very next cycle with no idle gap.
  - Otherwise Snap=1 while Busy is rejected and Overrun increments by 1, saturating at 255 (no wrap).
- Busy: high from the cycle after acceptance through the cycle of the final handshake. Busy=0 in the following cycle unless a back-to-back frame was accepted.
- Last: asserted only on beat N-1, and only while Valid=1.
- Outputs are registered or derived purely from registered state. There is no combinational path from Ready or Snap to Valid or DataOut.

Test Plan:
- Basic frame, LSB_FIRST=1: Cnt0=64'h0123456789ABCDEF, Cnt1=64'hFEDCBA9876543210, Ready=1 constant, Snap pulse at edge k -> DataOut over cycles k+1..k+17 = A5,EF,CD,AB,89,67,45,23,01,10,32,54,76,98,BA,DC,FE; Last only on FE; Busy=0 at k+18.
- Snapshot stability: same as the basic frame, but Cnt0 increments every cycle after edge k -> output bytes identical to the basic frame.
- Backpressure: Ready toggles 1,0,0,1,... -> each byte held stable during Ready=0; no byte lost or duplicated; 17 total transfers, in the basic-frame order.
- Overrun: Snap pulsed 3 times mid-frame -> Overrun=3 and the frame is unaffected. Hold Snap=1 while Busy for 300 cycles with Ready=0 -> Overrun saturates at 255.
- Back-to-back: Snap=1 on the edge of the FE/Last handshake, with Cnt0=1 and Cnt1=2 at that edge -> next cycle DataOut=A5, Valid=1, Busy stays 1; second frame carries 01,00..00,02,00..00; Overrun unchanged.
- Reset mid-frame: assert Reset during beat 5 -> next cycle Valid=0, Busy=0, Last=0, Overrun=0. A new Snap then starts a fresh frame with the A5 header.

Source files
------------

// File: rtl/counter_snapshot_serializer.sv
// Captures both 64-bit counters in one cycle on Snap and streams them out as a
// framed byte sequence (header, Cnt0 bytes, Cnt1 bytes) over valid/ready.
module counter_snapshot_serializer #(
  parameter int          DW        = 64,
  parameter bit          LSB_FIRST = 1'b1,
  parameter logic [7:0]  HDR       = 8'hA5
) (
  input  logic          Clk,
  input  logic          Reset,
  input  logic          Snap,
  input  logic [DW-1:0] Cnt0,
  input  logic [DW-1:0] Cnt1,
  input  logic          Ready,
  output logic          Valid,
  output logic [7:0]    DataOut,
  output logic          Last,
  output logic          Busy,
  output logic [7:0]    Overrun
);

  localparam int NB    = DW / 8;
  localparam int NBEAT = 2 * NB;
  localparam int IW    = (NBEAT > 1) ? $clog2(NBEAT) : 1;
  localparam logic [IW-1:0] IDX_LAST = IW'(NBEAT - 1);
  localparam logic [IW-1:0] NB_I     = IW'(NB);

  typedef enum logic [1:0] {IDLE, HEAD, DATA} state_t;

  state_t        state, state_nxt;
  logic [IW-1:0] idx, idx_nxt;
  logic [DW-1:0] snap0, snap1;
  logic [7:0]    ovr;
  logic          accept, reject;

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  // k is the position of the byte in transmit order within one counter
  function automatic logic [7:0] pick_byte(input logic [DW-1:0] w,
                                           input logic [IW-1:0] k);
    int pos;
    pos = LSB_FIRST ? int'(k) : NB - 1 - int'(k);
    return w[pos*8 +: 8];
  endfunction

  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    accept    = 1'b0;
    reject    = 1'b0;
    case (state)
      IDLE: begin
        if (Snap) begin
          accept    = 1'b1;
          state_nxt = HEAD;
        end
      end
      HEAD: begin
        if (Ready) begin
          state_nxt = DATA;
          idx_nxt   = '0;
        end
      end
      DATA: begin
        if (Ready) begin
          if (idx == IDX_LAST) begin
            idx_nxt = '0;
            // A snapshot on the final handshake chains straight into the next header
            if (Snap) begin
              accept    = 1'b1;
              state_nxt = HEAD;
            end else begin
              state_nxt = IDLE;
            end
          end else begin
            idx_nxt = idx + 1'b1;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
    reject = Snap && !accept && (state != IDLE);
  end

  // Stage p0: frame control and captured snapshot
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state <= IDLE;
      idx   <= '0;
    end else begin
      state <= state_nxt;
      idx   <= idx_nxt;
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      snap0 <= '0;
      snap1 <= '0;
      ovr   <= '0;
    end else begin
      if (accept) begin
        snap0 <= Cnt0;
        snap1 <= Cnt1;
      end
      if (reject) ovr <= sat_inc(ovr);
    end
  end

  always_comb begin
    DataOut = '0;
    case (state)
      HEAD:    DataOut = HDR;
      DATA:    DataOut = (idx < NB_I) ? pick_byte(snap0, idx)
                                      : pick_byte(snap1, idx - NB_I);
      default: DataOut = '0;
    endcase
  end

  assign Valid   = (state != IDLE);
  assign Busy    = (state != IDLE);
  assign Last    = (state == DATA) && (idx == IDX_LAST);
  assign Overrun = ovr;

endmodule

// File: tb/tb_counter_snapshot_serializer.sv
// Scoreboard bench: driver models each clock edge and queues expected beats,
// a negedge monitor compares DUT outputs against the queue.
module tb_counter_snapshot_serializer;

  localparam logic [7:0] HDR = 8'hA5;
  localparam int NB = 8;

  logic        Clk = 1'b0;
  logic        Reset = 1'b1;
  logic        Snap = 1'b0;
  logic [63:0] Cnt0 = '0;
  logic [63:0] Cnt1 = '0;
  logic        Ready = 1'b0;
  logic        Valid, Last, Busy;
  logic [7:0]  DataOut, Overrun;

  counter_snapshot_serializer #(.DW(64), .LSB_FIRST(1'b1), .HDR(HDR)) dut (
    .Clk(Clk), .Reset(Reset), .Snap(Snap), .Cnt0(Cnt0), .Cnt1(Cnt1),
    .Ready(Ready), .Valid(Valid), .DataOut(DataOut), .Last(Last),
    .Busy(Busy), .Overrun(Overrun)
  );

  always #5 Clk = ~Clk;

  typedef struct {logic [7:0] d; logic l;} beat_t;
  beat_t q[$];
  int    rem = 0;
  int    ovr = 0;
  bit    after_rst = 1'b0;
  int    checks = 0;
  int    fails = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Effect of the edge that just occurred, using the inputs held across it
  task automatic model_edge();
    bit xfer, acc;
    beat_t b;
    xfer = (rem > 0) && Ready;
    if (Reset) begin
      rem = 0; ovr = 0; q.delete(); after_rst = 1'b1;
      return;
    end
    after_rst = 1'b0;
    acc = Snap && ((rem == 0) || (xfer && rem == 1));
    if (Snap && !acc) ovr = (ovr == 255) ? 255 : ovr + 1;
    if (xfer) rem--;
    if (acc) begin
      b.d = HDR; b.l = 1'b0; q.push_back(b);
      for (int i = 0; i < 2*NB; i++) begin
        b.d = (i < NB) ? 8'((Cnt0 >> (8*i)) & 64'hFF) : 8'((Cnt1 >> (8*(i-NB))) & 64'hFF);
        b.l = (i == 2*NB-1);
        q.push_back(b);
      end
      rem = 1 + 2*NB;
    end
  endtask

  task automatic cyc(input bit s, input bit r, input bit rs,
                     input logic [63:0] c0, input logic [63:0] c1);
    Snap = s; Ready = r; Reset = rs; Cnt0 = c0; Cnt1 = c1;
    @(posedge Clk);
    model_edge();
    #1;
  endtask

  always @(negedge Clk) begin
    chk("valid", Valid, rem > 0);
    chk("busy", Busy, rem > 0);
    chk("overrun", Overrun, ovr);
    if (after_rst) begin
      chk("rst_dataout", DataOut, 0);
      chk("rst_last", Last, 0);
    end
    if (Valid) begin
      if (q.size() == 0) begin
        chk("queue_has_beat", 0, 1);
      end else begin
        chk("dataout", DataOut, q[0].d);
        chk("last", Last, q[0].l);
        if (Ready && !Reset) void'(q.pop_front());
      end
    end else begin
      chk("last_idle", Last, 0);
    end
  end

  localparam logic [63:0] A = 64'h0123456789ABCDEF;
  localparam logic [63:0] B = 64'hFEDCBA9876543210;

  initial begin
    // reset
    repeat (3) cyc(0, 0, 1, 0, 0);
    cyc(0, 1, 0, A, B);
    // basic frame
    cyc(1, 1, 0, A, B);
    repeat (20) cyc(0, 1, 0, A, B);
    // snapshot stability: Cnt0 moves every cycle
    cyc(1, 1, 0, A, B);
    for (int i = 1; i <= 20; i++) cyc(0, 1, 0, A + 64'(i), B);
    // backpressure 1,0,0,1
    cyc(1, 1, 0, A, B);
    for (int i = 0; i < 60; i++) cyc(0, (i % 4 == 0) || (i % 4 == 3), 0, A, B);
    // three rejected snaps mid-frame
    cyc(1, 1, 0, A, B);
    for (int i = 0; i < 20; i++) cyc(i == 3 || i == 7 || i == 11, 1, 0, A, B);
    // saturation with stalled sink
    cyc(1, 1, 0, A, B);
    repeat (300) cyc(1, 0, 0, A, B);
    repeat (20) cyc(0, 1, 0, A, B);
    repeat (2) cyc(0, 1, 1, A, B);
    // back-to-back on the Last handshake
    cyc(1, 1, 0, A, B);
    repeat (16) cyc(0, 1, 0, A, B);
    cyc(1, 1, 0, 64'd1, 64'd2);
    repeat (20) cyc(0, 1, 0, A, B);
    // reset during beat 5, then a fresh frame
    cyc(1, 0, 0, A, B);
    repeat (2) cyc(1, 1, 0, A, B);
    repeat (4) cyc(0, 1, 0, A, B);
    cyc(0, 1, 1, A, B);
    cyc(0, 1, 0, A, B);
    cyc(1, 1, 0, B, A);
    repeat (20) cyc(0, 1, 0, A, B);
    // randomized traffic
    for (int i = 0; i < 3000; i++)
      cyc($urandom_range(0, 9) == 0, $urandom_range(0, 3) != 0,
          $urandom_range(0, 299) == 0, {$urandom, $urandom}, {$urandom, $urandom});
    repeat (30) cyc(0, 1, 0, A, B);
    chk("drained", q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
